// File: rtl/ucsbece154b_branch_resolve_if.sv
// Predictor/resolver bus: fetch-time prediction in, execute-stage update out.
// The predictor side uses master, the resolver uses slave.
interface ucsbece154b_branch_resolve_if #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
);
    localparam int BW = $clog2(NUM_BTB_ENTRIES);

    logic                    StallD_i;
    logic                    FlushD_i;
    logic                    FlushE_i;
    logic [31:0]             PCF_i;
    logic                    BranchTakenF_i;
    logic [31:0]             BTBtargetF_i;
    logic [NUM_GHR_BITS-1:0] PHTreadaddressF_i;
    logic [6:0]              opE_i;
    logic                    ActualTakenE_i;
    logic [31:0]             PCTargetE_i;

    logic                    MispredictE_o;
    logic [31:0]             PCcorrectE_o;
    logic                    BTB_we_o;
    logic [BW-1:0]           BTBwriteaddress_o;
    logic [31:0]             BTBwritedata_o;
    logic                    PHTwe_o;
    logic                    PHTincrement_o;
    logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
    logic                    GHRreset_o;
    logic [31:0]             BranchCount_o;
    logic [31:0]             MispredictCount_o;

    modport master (
        output StallD_i, FlushD_i, FlushE_i,
        output PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
        output opE_i, ActualTakenE_i, PCTargetE_i,
        input  MispredictE_o, PCcorrectE_o,
        input  BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
        input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
        input  GHRreset_o, BranchCount_o, MispredictCount_o
    );

    modport slave (
        input  StallD_i, FlushD_i, FlushE_i,
        input  PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
        input  opE_i, ActualTakenE_i, PCTargetE_i,
        output MispredictE_o, PCcorrectE_o,
        output BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
        output PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
        output GHRreset_o, BranchCount_o, MispredictCount_o
    );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Carries fetch predictions through D/E and resolves them in E.
// Define BRANCH_STATS_EN to get branch / mispredict counters.
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input logic clk,
    input logic reset_n_i,
    ucsbece154b_branch_resolve_if.slave bus
);
    localparam int BW = $clog2(NUM_BTB_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic                    taken;
        logic [31:0]             target;
        logic [NUM_GHR_BITS-1:0] pht;
    } meta_t;

    meta_t d_q, d_d;
    meta_t e_q, e_d;
    logic  ghr_rst_q, ghr_rst_d;

    always_comb begin
        d_d = d_q;
        if (bus.FlushD_i) begin
            d_d = '0;
        end else if (!bus.StallD_i) begin
            d_d = '{valid:  1'b1,
                    pc:     bus.PCF_i,
                    taken:  bus.BranchTakenF_i,
                    target: bus.BTBtargetF_i,
                    pht:    bus.PHTreadaddressF_i};
        end
        e_d       = bus.FlushE_i ? '0 : d_q;
        ghr_rst_d = 1'b0;
    end

    logic is_b, is_j, ctl, actual, tgt_miss, mispredict;

    always_comb begin
        is_b     = bus.opE_i == 7'b1100011;
        is_j     = (bus.opE_i == 7'b1101111) | (bus.opE_i == 7'b1100111);
        ctl      = is_b | is_j;
        actual   = is_j | (is_b & bus.ActualTakenE_i);
        tgt_miss = e_q.target != bus.PCTargetE_i;
        // A non-control op predicted taken is a BTB alias and must redirect
        mispredict = e_q.valid &
                     ((ctl & ((e_q.taken != actual) | (actual & tgt_miss)))
                     | (~ctl & e_q.taken));
    end

    assign bus.MispredictE_o     = mispredict;
    assign bus.PCcorrectE_o      = !mispredict ? 32'h0 :
                                   actual ? bus.PCTargetE_i : e_q.pc + 32'd4;
    assign bus.BTB_we_o          = e_q.valid & ctl & tgt_miss;
    assign bus.BTBwriteaddress_o = e_q.pc[BW+1:2];
    assign bus.BTBwritedata_o    = bus.PCTargetE_i;
    assign bus.PHTwe_o           = e_q.valid & is_b;
    assign bus.PHTincrement_o    = bus.ActualTakenE_i;
    assign bus.PHTwriteaddress_o = e_q.pht;
    assign bus.GHRreset_o        = ~reset_n_i | ghr_rst_q;

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            d_q       <= '0;
            e_q       <= '0;
            ghr_rst_q <= 1'b1;
        end else begin
            d_q       <= d_d;
            e_q       <= e_d;
            ghr_rst_q <= ghr_rst_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q + {31'h0, e_q.valid & ctl};
        mp_cnt_d = mp_cnt_q + {31'h0, mispredict};
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign bus.BranchCount_o     = br_cnt_q;
    assign bus.MispredictCount_o = mp_cnt_q;
`else
    assign bus.BranchCount_o     = 32'h0;
    assign bus.MispredictCount_o = 32'h0;
`endif
endmodule
